// File: rtl/lane_dispatch_if.sv
// Job intake handshake between an upstream producer and lane_dispatch.
// The producer drives valid/id; the dispatcher answers with ready.
interface lane_dispatch_if #(
    parameter int IDW = 16
);
    logic           job_valid;
    logic [IDW-1:0] job_id;
    logic           job_ready;

    modport master (
        output job_valid,
        output job_id,
        input  job_ready
    );

    modport slave (
        input  job_valid,
        input  job_id,
        output job_ready
    );
endinterface

// File: rtl/lane_dispatch.sv
// Round-robin job scheduler: walks an external one-hot lane pointer,
// skips busy lanes and issues each accepted job to the lane under it.
module lane_dispatch #(
    parameter int NB  = 8,
    parameter int IDW = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    lane_dispatch_if.slave         job,
    input  logic [NB-1:0]          mask_i,
    input  logic [NB-1:0]          lane_done_i,
    output logic                   shift_enable_o,
    output logic [NB-1:0]          lane_start_o,
    output logic [IDW-1:0]         lane_id_o,
    output logic [NB-1:0]          busy_o,
    output logic [$clog2(NB+1)-1:0] outstanding_o,
    output logic                   idle_o,
    output logic                   err_o
);
    localparam int CW = $clog2(NB + 1);

    typedef enum logic {
        SEEK,
        FULL
    } state_e;

    state_e         state_q, state_d;
    logic [NB-1:0]  busy_q, busy_d;
    logic [NB-1:0]  start_q, start_d;
    logic [IDW-1:0] id_q, id_d;
    logic           err_q, err_d;

    logic           onehot;
    logic           free_here;
    logic           any_free;
    logic           ready;
    logic           shift;
    logic           fire;
    logic [NB-1:0]  issue;
    logic [CW-1:0]  count;

    assign onehot    = (mask_i != '0) && ((mask_i & (mask_i - 1'b1)) == '0);
    assign free_here = |(mask_i & ~busy_q);
    assign any_free  = |(~busy_q);

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        ready   = 1'b0;
        shift   = 1'b0;
        fire    = 1'b0;
        issue   = '0;
        unique case (state_q)
            SEEK: begin
                if (!onehot) begin
                    err_d = 1'b1;
                end else begin
                    ready = free_here;
                    fire  = job.job_valid & free_here;
                    if (fire) begin
                        issue = mask_i;
                        shift = 1'b1;
                    end else if (!free_here && any_free) begin
                        shift = 1'b1;
                    end
                end
            end
            FULL: begin
                if (|lane_done_i) state_d = SEEK;
            end
            default: state_d = SEEK;
        endcase

        // A done and an issue on the same lane leave the bit set.
        busy_d = (busy_q & ~lane_done_i) | issue;
        if (state_q == SEEK && busy_d == '1) state_d = FULL;

        start_d = issue;
        id_d    = fire ? job.job_id : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEEK;
            busy_q  <= '0;
            start_q <= '0;
            id_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            start_q <= start_d;
            id_q    <= id_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < NB; i++) begin
            count = count + CW'(busy_q[i]);
        end
    end

    assign job.job_ready  = ready & ~rst;
    assign shift_enable_o = shift & ~rst;
    assign lane_start_o   = start_q;
    assign lane_id_o      = id_q;
    assign busy_o         = busy_q;
    assign outstanding_o  = count;
    assign idle_o         = (busy_q == '0);
    assign err_o          = err_q;
endmodule
